systolic_ctrl: RTL and testbench

- Sequencer that drives `systolic_array`. It is the RTL replacement for the stimulus side that the array benches currently drive by hand.
- Accepts a weight-row stream and loads it row by row via one-hot `row_load_en`.
- Then streams activation vectors under `en_compute`, tags each beat through the array latency, and emits `out_psum_vec` as a valid-qualified result stream.
- Sits between the on-chip buffers and `systolic_array`.

---
 rtl/systolic_ctrl.sv | 166 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer in front of systolic_array.
// Loads ARRAY_ROW weight rows one-hot via sa_row_load_en, then streams activation
// vectors under sa_en_compute. A valid/last tag follows each beat through a
// LATENCY-deep pipe, so r_valid/r_last line up with the psum vector the array
// returns for that beat.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start / busy / done    job control: start pulse, busy level, done pulse
//   w_valid/w_ready/w_data weight-row stream (one row per handshake)
//   a_valid/a_ready/a_data activation stream, a_last marks the final beat
//   sa_*                   drive/return signals of systolic_array
//   r_valid/r_last/r_data  result stream, no backpressure; r_data = sa_psum_vec
module systolic_ctrl #(
  parameter int unsigned ARRAY_ROW  = 8,
  parameter int unsigned ARRAY_COL  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LATENCY    = 18
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [ARRAY_COL*DATA_WIDTH-1:0] w_data,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ARRAY_ROW*DATA_WIDTH-1:0] a_data,
  input  logic                            a_last,
  output logic [ARRAY_ROW-1:0]            sa_row_load_en,
  output logic [ARRAY_COL*DATA_WIDTH-1:0] sa_weight_vec,
  output logic                            sa_en_compute,
  output logic [ARRAY_ROW*DATA_WIDTH-1:0] sa_act_vec,
  input  logic [ARRAY_COL*ACC_WIDTH-1:0]  sa_psum_vec,
  output logic                            r_valid,
  output logic                            r_last,
  output logic [ARRAY_COL*ACC_WIDTH-1:0]  r_data
);

  localparam int unsigned ROW_CW = $clog2(ARRAY_ROW + 1);
  localparam int unsigned LAT_CW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state;
  logic [ROW_CW-1:0]   row_cnt;
  logic [LAT_CW-1:0]   lat_cnt;
  logic [LATENCY-1:0]  tag_v;
  logic [LATENCY-1:0]  tag_l;
  logic                w_fire;
  logic                a_fire;

  assign w_fire = (state == LOAD_W) && w_valid && w_ready;
  assign a_fire = (state == COMPUTE) && a_valid && a_ready;

  // Results are the array output itself; only the qualifiers are generated here.
  assign r_data = sa_psum_vec;

  // Sequencer, tag pipe and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      row_cnt        <= '0;
      lat_cnt        <= '0;
      tag_v          <= '0;
      tag_l          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_ready        <= 1'b0;
      a_ready        <= 1'b0;
      sa_row_load_en <= '0;
      sa_weight_vec  <= '0;
      sa_en_compute  <= 1'b0;
      sa_act_vec     <= '0;
      r_valid        <= 1'b0;
      r_last         <= 1'b0;
    end else begin
      done           <= 1'b0;
      sa_row_load_en <= '0;

      // Tag pipe moves in lockstep with the array, i.e. only while it computes.
      // Stage 0 holds the tag of the vector presented this cycle (bubble = 0).
      if (sa_en_compute) begin
        tag_v[0] <= a_fire;
        tag_l[0] <= a_fire && a_last;
        for (int i = 1; i < int'(LATENCY); i++) begin
          tag_v[i] <= tag_v[i-1];
          tag_l[i] <= tag_l[i-1];
        end
        r_valid <= tag_v[LATENCY-1];
        r_last  <= tag_l[LATENCY-1];
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_W;
            row_cnt <= '0;
            busy    <= 1'b1;
            w_ready <= 1'b1;
          end
        end

        LOAD_W: begin
          if (w_fire) begin
            sa_weight_vec  <= w_data;
            sa_row_load_en <= ARRAY_ROW'(1) << row_cnt;
            row_cnt        <= row_cnt + ROW_CW'(1);
            // Last row: the array still sees its load strobe in the first
            // COMPUTE cycle, while the activation input is still zero.
            if (row_cnt == ROW_CW'(ARRAY_ROW - 1)) begin
              state         <= COMPUTE;
              w_ready       <= 1'b0;
              a_ready       <= 1'b1;
              sa_en_compute <= 1'b1;
            end
          end
        end

        COMPUTE: begin
          if (a_fire) begin
            sa_act_vec <= a_data;
            if (a_last) begin
              state   <= DRAIN;
              a_ready <= 1'b0;
              lat_cnt <= '0;
            end
          end else begin
            sa_act_vec <= '0;
          end
        end

        // LATENCY+1 cycles so the last beat's result lands in the final DRAIN cycle.
        DRAIN: begin
          sa_act_vec <= '0;
          if (lat_cnt == LAT_CW'(LATENCY)) begin
            state         <= DONE;
            sa_en_compute <= 1'b0;
            done          <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_CW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a behavioural weight-stationary array
// model (psum[c] = sum_r act[r]*w[r][c], LAT cycles after presentation).
module tb_systolic_ctrl;

  localparam int unsigned AR  = 8;
  localparam int unsigned AC  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               w_valid = 1'b0;
  logic               a_valid = 1'b0;
  logic               a_last = 1'b0;
  logic [AC*DW-1:0]   w_data = '0;
  logic [AR*DW-1:0]   a_data = '0;
  logic               busy, done, w_ready, a_ready, sa_en_compute, r_valid, r_last;
  logic [AR-1:0]      sa_row_load_en;
  logic [AC*DW-1:0]   sa_weight_vec;
  logic [AR*DW-1:0]   sa_act_vec;
  logic [AC*AW-1:0]   sa_psum_vec;
  logic [AC*AW-1:0]   r_data;

  int checks = 0;
  int errors = 0;

  systolic_ctrl #(
    .ARRAY_ROW(AR), .ARRAY_COL(AC), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .sa_row_load_en(sa_row_load_en), .sa_weight_vec(sa_weight_vec),
    .sa_en_compute(sa_en_compute), .sa_act_vec(sa_act_vec), .sa_psum_vec(sa_psum_vec),
    .r_valid(r_valid), .r_last(r_last), .r_data(r_data)
  );

  always #5 clk = ~clk;

  // ---------------- array model ----------------
  logic [AC*DW-1:0] w_mem [AR];
  logic [AC*AW-1:0] dline [LAT];

  function automatic logic [AC*AW-1:0] mac(input logic [AR*DW-1:0] act);
    logic [AC*AW-1:0] res;
    res = '0;
    for (int c = 0; c < int'(AC); c++) begin
      int s;
      s = 0;
      for (int r = 0; r < int'(AR); r++)
        s += int'(act[r*DW +: DW]) * int'(w_mem[r][c*DW +: DW]);
      res[c*AW +: AW] = 32'(s);
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) dline[i] <= '0;
    end else begin
      for (int r = 0; r < int'(AR); r++)
        if (sa_row_load_en[r]) w_mem[r] <= sa_weight_vec;
      if (sa_en_compute) begin
        dline[0] <= mac(sa_act_vec);
        for (int i = 1; i < int'(LAT); i++) dline[i] <= dline[i-1];
      end
    end
  end
  assign sa_psum_vec = dline[LAT-1];

  // ---------------- monitor ----------------
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int               res_cyc[$];
  bit               res_last[$];
  logic [AC*AW-1:0] res_dat[$];
  int               done_cnt = 0;
  int               done_cyc = 0;

  // Cycle index = number of the edge that ended it; cycle e+1 follows edge e.
  always @(negedge clk) begin
    if (r_valid) begin
      res_cyc.push_back(edge_n + 1);
      res_last.push_back(r_last);
      res_dat.push_back(r_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = edge_n + 1;
    end
  end

  int exp_cyc[$];
  bit exp_last[$];
  int exp_scale[$];
  int last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AC*DW-1:0] wrow();
    logic [AC*DW-1:0] v;
    for (int c = 0; c < int'(AC); c++) v[c*DW +: DW] = 8'(c + 1);
    return v;
  endfunction

  function automatic logic [AR*DW-1:0] act_vec(input int scale);
    logic [AR*DW-1:0] v;
    for (int r = 0; r < int'(AR); r++) v[r*DW +: DW] = 8'((r + 1) * scale);
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, w_ready, a_ready, sa_en_compute, r_valid, r_last}), 64'(0));
    check({tag, "_row_en"}, 64'(sa_row_load_en), 64'(0));
    check({tag, "_wvec"}, 64'(sa_weight_vec), 64'(0));
    check({tag, "_avec"}, 64'(sa_act_vec), 64'(0));
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic load_weights(input int gap_after, input bit poke_start);
    for (int i = 0; i < int'(AR); i++) begin
      w_valid = 1'b1;
      w_data  = wrow();
      check("w_ready", 64'(w_ready), 64'(1));
      @(negedge clk);
      check("row_en", 64'(sa_row_load_en), 64'(1) << i);
      check("w_vec", 64'(sa_weight_vec), 64'(wrow()));
      if (i == gap_after) begin
        w_valid = 1'b0;
        start   = poke_start;
        repeat (2) begin
          @(negedge clk);
          start = 1'b0;
          check("row_gap", 64'(sa_row_load_en), 64'(0));
        end
      end
    end
    w_valid = 1'b0;
    check("w_ready_off", 64'(w_ready), 64'(0));
  endtask

  task automatic send_acts(input int n, input int gap_after, input bit mark_last);
    for (int b = 0; b < n; b++) begin
      a_valid = 1'b1;
      a_data  = act_vec(b + 1);
      a_last  = mark_last && (b == n - 1);
      check("a_ready", 64'(a_ready), 64'(1));
      last_acc = edge_n + 1;
      exp_cyc.push_back(last_acc + 1 + int'(LAT));
      exp_last.push_back(a_last);
      exp_scale.push_back(b + 1);
      @(negedge clk);
      check("act_vec", 64'(sa_act_vec), 64'(act_vec(b + 1)));
      check("en_comp", 64'(sa_en_compute), 64'(1));
      if (b == gap_after) begin
        a_valid = 1'b0;
        a_last  = 1'b0;
        @(negedge clk);
        check("act_bubble", 64'(sa_act_vec), 64'(0));
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    if (mark_last) check("a_ready_off", 64'(a_ready), 64'(0));
  endtask

  task automatic finish_job(input bit poke_start);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    if (poke_start) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'(1));
    check("done_cyc", 64'(done_cyc), 64'(last_acc + 2 + int'(LAT)));
    @(negedge clk);
    check("busy_after", 64'(busy), 64'(0));
    check("en_after", 64'(sa_en_compute), 64'(0));
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'(1));
    check("still_idle", 64'({busy, w_ready}), 64'(0));
  endtask

  task automatic check_results();
    int n;
    check("n_results", 64'(res_cyc.size()), 64'(exp_cyc.size()));
    n = (res_cyc.size() < exp_cyc.size()) ? res_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check("r_cycle", 64'(res_cyc[i]), 64'(exp_cyc[i]));
      check("r_last", 64'(res_last[i]), 64'(exp_last[i]));
      for (int c = 0; c < int'(AC); c++)
        check("r_data", 64'(res_dat[i][c*AW +: AW]), 64'(36 * (c + 1) * exp_scale[i]));
    end
    res_cyc.delete(); res_last.delete(); res_dat.delete();
    exp_cyc.delete(); exp_last.delete(); exp_scale.delete();
  endtask

  initial begin
    int d0;
    // Reset with inputs toggling and start held high.
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_valid = ~w_valid;
      a_valid = ~a_valid;
      a_last  = ~a_last;
      w_data  = ~w_data;
      a_data  = ~a_data;
    end
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    w_data = '0; a_data = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_rst");

    // Job 1: gapped weight load, single activation, start pokes ignored.
    do_start();
    check("busy_job", 64'(busy), 64'(1));
    load_weights(3, 1'b1);
    send_acts(1, -1, 1'b1);
    finish_job(1'b1);
    check_results();

    // Job 2: four beats with one bubble after beat 2.
    do_start();
    load_weights(-1, 1'b0);
    send_acts(4, 1, 1'b1);
    finish_job(1'b0);
    check_results();

    // Job 3: reset in the middle of COMPUTE after two beats.
    do_start();
    load_weights(-1, 1'b0);
    send_acts(2, -1, 1'b0);
    rst_n = 1'b0;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    check_idle_outputs("mid_rst");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_results", 64'(res_cyc.size()), 64'(0));
    check("abort_done", 64'(done_cnt - d0), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    res_cyc.delete(); res_last.delete(); res_dat.delete();
    exp_cyc.delete(); exp_last.delete(); exp_scale.delete();

    // Job 4: clean single-activation job after the abort.
    do_start();
    load_weights(-1, 1'b0);
    send_acts(1, -1, 1'b1);
    finish_job(1'b0);
    check_results();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
